// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared types and constants for the fetch PC controller: FSM encoding,
// reset PC default, widths and the sequential next-PC helper.
package fetch_pc_ctrl_pkg;

  localparam int unsigned AddrWidth  = 32;
  localparam int unsigned InstrWidth = 32;

  localparam logic [AddrWidth-1:0] FpcResetPc = 32'h0000_0000;

  typedef enum logic [1:0] {
    FpcReq     = 2'd0,
    FpcWait    = 2'd1,
    FpcDiscard = 2'd2
  } fpc_state_e;

  // Sequential fetch address; wraps modulo 2^32.
  function automatic logic [AddrWidth-1:0] seq_pc(input logic [AddrWidth-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// AXI4-Lite style read channel between the fetch controller (master) and
// instruction memory (slave): address request plus read-data response.
interface fetch_pc_ctrl_if;
  import fetch_pc_ctrl_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic [AddrWidth-1:0]  req_addr;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [InstrWidth-1:0] rsp_data;

  modport master (
    output req_valid,
    output req_addr,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );

endinterface

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC owner: issues one instruction read at a time, picks the next PC
// from PC+4 / BTB prediction / mem-stage redirect, and feeds the IF/ID stage.
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FpcResetPc
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_i,
  input  logic                  redirect_valid_i,
  input  logic [AddrWidth-1:0]  redirect_pc_i,
  input  logic                  btb_hit_i,
  input  logic                  btb_taken_i,
  input  logic [AddrWidth-1:0]  btb_target_i,
  output logic [AddrWidth-1:0]  btb_pc_o,
  fetch_pc_ctrl_if.master       imem,
  output logic                  if_valid_o,
  output logic [AddrWidth-1:0]  if_pc_o,
  output logic [InstrWidth-1:0] if_instr_o,
  output logic                  if_pred_taken_o,
  output logic                  flush_o
);

  fpc_state_e state_q, state_d;

  logic [AddrWidth-1:0]  pc_q, pc_d;
  logic [AddrWidth-1:0]  req_addr_q, req_addr_d;
  logic                  pred_q, pred_d;
  logic [AddrWidth-1:0]  pred_tgt_q, pred_tgt_d;
  logic                  kill_q, kill_d;
  logic                  out_valid_q, out_valid_d;
  logic [AddrWidth-1:0]  out_pc_q, out_pc_d;
  logic [InstrWidth-1:0] out_instr_q, out_instr_d;
  logic                  out_pred_q, out_pred_d;

  logic                  req_valid;
  logic                  rsp_ready;
  logic                  rsp_fire;
  logic [AddrWidth-1:0]  next_pc;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FpcReq;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath next values; redirect overrides everything else.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    pred_d      = pred_q;
    pred_tgt_d  = pred_tgt_q;
    kill_d      = kill_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    out_pred_d  = out_pred_q;
    rsp_fire    = imem.rsp_valid & rsp_ready;
    next_pc     = pred_q ? pred_tgt_q : seq_pc(req_addr_q);

    if (out_valid_q && !stall_i) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      FpcReq: begin
        if (imem.req_ready) begin
          pred_d     = btb_hit_i & btb_taken_i;
          pred_tgt_d = btb_target_i;
          kill_d     = 1'b0;
          state_d    = (kill_q || redirect_valid_i) ? FpcDiscard : FpcWait;
        end else if (redirect_valid_i) begin
          // Address must stay stable until accepted; remember to drop its data.
          kill_d = 1'b1;
        end
      end
      FpcWait: begin
        if (rsp_fire) begin
          state_d = FpcReq;
          if (redirect_valid_i) begin
            req_addr_d = redirect_pc_i;
          end else begin
            out_valid_d = 1'b1;
            out_pc_d    = req_addr_q;
            out_instr_d = imem.rsp_data;
            out_pred_d  = pred_q;
            pc_d        = next_pc;
            req_addr_d  = next_pc;
          end
        end else if (redirect_valid_i) begin
          state_d = FpcDiscard;
        end
      end
      FpcDiscard: begin
        if (imem.rsp_valid) begin
          state_d    = FpcReq;
          req_addr_d = redirect_valid_i ? redirect_pc_i : pc_q;
        end
      end
      default: state_d = FpcReq;
    endcase

    if (redirect_valid_i) begin
      pc_d        = redirect_pc_i;
      out_valid_d = 1'b0;
      out_pc_d    = '0;
      out_instr_d = '0;
      out_pred_d  = 1'b0;
    end
  end

  // Handshake outputs; request is gated by rst_n so it stays low during reset.
  always_comb begin
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    unique case (state_q)
      FpcReq:     req_valid = rst_n;
      FpcWait:    rsp_ready = !out_valid_q | !stall_i;
      FpcDiscard: rsp_ready = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      pred_q      <= 1'b0;
      pred_tgt_q  <= '0;
      kill_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
      out_pred_q  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      pred_q      <= pred_d;
      pred_tgt_q  <= pred_tgt_d;
      kill_q      <= kill_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      out_pred_q  <= out_pred_d;
    end
  end

  assign imem.req_valid  = req_valid;
  assign imem.req_addr   = {req_addr_q[AddrWidth-1:2], 2'b00};
  assign imem.rsp_ready  = rsp_ready;
  assign btb_pc_o        = {req_addr_q[AddrWidth-1:2], 2'b00};
  assign if_valid_o      = out_valid_q;
  assign if_pc_o         = out_pc_q;
  assign if_instr_o      = out_instr_q;
  assign if_pred_taken_o = out_pred_q;
  assign flush_o         = redirect_valid_i & rst_n;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Self-checking bench for fetch_pc_ctrl: table-driven fetch sequences plus
// hand-written redirect, stall and reset corner cases.
module tb_fetch_pc_ctrl;
  import fetch_pc_ctrl_pkg::*;

  typedef struct packed {
    logic [3:0]       lat;
    logic             btb_en;
    logic [31:0]      btb_key;
    logic [31:0]      btb_tgt;
    logic [3:0][31:0] exp_addr;
    logic [3:0]       exp_pred;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred;
  } del_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        btb_en;
  logic [31:0] btb_key;
  logic [31:0] btb_tgt;
  logic        btb_hit;
  logic        btb_taken;
  logic [31:0] btb_pc;
  logic        ready_en;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_pred;
  logic        flush;

  int          latency;
  logic        mem_reset;
  logic [31:0] accq[$];
  del_t        delq[$];
  int          total  = 0;
  int          passed = 0;
  vec_t        vecs[4];

  fetch_pc_ctrl_if imem_if ();

  always #5 clk = ~clk;

  assign imem_if.req_ready = ready_en;
  assign btb_hit           = btb_en && (btb_pc == btb_key);
  assign btb_taken         = 1'b1;

  fetch_pc_ctrl #(
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_i          (stall),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .btb_hit_i        (btb_hit),
    .btb_taken_i      (btb_taken),
    .btb_target_i     (btb_tgt),
    .btb_pc_o         (btb_pc),
    .imem             (imem_if),
    .if_valid_o       (if_valid),
    .if_pc_o          (if_pc),
    .if_instr_o       (if_instr),
    .if_pred_taken_o  (if_pred),
    .flush_o          (flush)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hDEAD_0013;
  endfunction

  function automatic vec_t mk(input logic [3:0] lat, input logic en, input logic [31:0] key,
                              input logic [31:0] tgt, input logic [31:0] a0,
                              input logic [31:0] a1, input logic [31:0] a2,
                              input logic [31:0] a3, input logic [3:0] pred);
    vec_t r;
    r.lat = lat;
    r.btb_en = en;
    r.btb_key = key;
    r.btb_tgt = tgt;
    r.exp_addr[0] = a0;
    r.exp_addr[1] = a1;
    r.exp_addr[2] = a2;
    r.exp_addr[3] = a3;
    r.exp_pred = pred;
    return r;
  endfunction

  // Instruction memory: fixed latency per accepted address, holds rsp_valid until taken.
  initial begin
    logic        req_fire;
    logic        rsp_fire;
    logic        pending;
    int          wait_cnt;
    logic [31:0] fire_addr;
    logic [31:0] pend_addr;
    imem_if.rsp_valid = 1'b0;
    imem_if.rsp_data  = '0;
    pending   = 1'b0;
    wait_cnt  = 0;
    pend_addr = '0;
    forever begin
      @(negedge clk);
      req_fire  = imem_if.req_valid && imem_if.req_ready;
      rsp_fire  = imem_if.rsp_valid && imem_if.rsp_ready;
      fire_addr = imem_if.req_addr;
      @(posedge clk);
      #1;
      if (mem_reset) begin
        pending = 1'b0;
        imem_if.rsp_valid = 1'b0;
      end else begin
        if (rsp_fire) imem_if.rsp_valid = 1'b0;
        if (pending) begin
          wait_cnt--;
          if (wait_cnt <= 0) begin
            imem_if.rsp_valid = 1'b1;
            imem_if.rsp_data  = instr_of(pend_addr);
            pending = 1'b0;
          end
        end
        if (req_fire) begin
          accq.push_back(fire_addr);
          pend_addr = fire_addr;
          wait_cnt  = latency - 1;
          if (wait_cnt <= 0) begin
            imem_if.rsp_valid = 1'b1;
            imem_if.rsp_data  = instr_of(fire_addr);
          end else begin
            pending = 1'b1;
          end
        end
      end
    end
  end

  // IF/ID consumer log.
  initial begin
    del_t d;
    forever begin
      @(negedge clk);
      if (rst_n && if_valid && !stall) begin
        d.pc = if_pc;
        d.instr = if_instr;
        d.pred = if_pred;
        delq.push_back(d);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %08h, want %08h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b, want %b", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_del(input int n, input string name);
    int c = 0;
    while (delq.size() < n && c < 200) begin
      step();
      c++;
    end
    check(name, delq.size(), n);
  endtask

  task automatic wait_acc(input int n, input string name);
    int c = 0;
    while (accq.size() < n && c < 200) begin
      step();
      c++;
    end
    check(name, accq.size(), n);
  endtask

  task automatic wait_valid(input string name);
    int c = 0;
    while (!if_valid && c < 200) begin
      step();
      c++;
    end
    check1(name, if_valid, 1'b1);
  endtask

  task automatic do_reset(input int lat, input logic rdy);
    rst_n          = 1'b0;
    mem_reset      = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    ready_en       = rdy;
    latency        = lat;
    step();
    check1("rst req_valid", imem_if.req_valid, 1'b0);
    check1("rst rsp_ready", imem_if.rsp_ready, 1'b0);
    check1("rst if_valid", if_valid, 1'b0);
    check("rst if_pc", if_pc, 32'h0);
    check("rst if_instr", if_instr, 32'h0);
    check1("rst pred", if_pred, 1'b0);
    check1("rst flush", flush, 1'b0);
    step();
    accq.delete();
    delq.delete();
    mem_reset = 1'b0;
    rst_n     = 1'b1;
    #1;
    check1("first req_valid", imem_if.req_valid, 1'b1);
    check("first req_addr", imem_if.req_addr, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; mem_reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; btb_en = 1'b0; btb_key = '0; btb_tgt = '0;
    ready_en = 1'b1; latency = 1;

    vecs[0] = mk(4'd1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h8, 32'hC, 4'b0000);
    vecs[1] = mk(4'd1, 1'b1, 32'h8, 32'h40, 32'h0, 32'h4, 32'h8, 32'h40, 4'b0100);
    vecs[2] = mk(4'd3, 1'b1, 32'h0, 32'h20, 32'h0, 32'h20, 32'h24, 32'h28, 4'b0001);
    vecs[3] = mk(4'd2, 1'b1, 32'h4, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'hFFFF_FFFC, 32'h0,
                 4'b0010);

    for (int v = 0; v < 4; v++) begin
      btb_en  = vecs[v].btb_en;
      btb_key = vecs[v].btb_key;
      btb_tgt = vecs[v].btb_tgt;
      do_reset(int'(vecs[v].lat), 1'b1);
      wait_del(4, $sformatf("v%0d delivered", v));
      for (int i = 0; i < 4; i++) begin
        check($sformatf("v%0d addr%0d", v, i), accq[i], vecs[v].exp_addr[i]);
        check($sformatf("v%0d pc%0d", v, i), delq[i].pc, vecs[v].exp_addr[i]);
        check($sformatf("v%0d instr%0d", v, i), delq[i].instr, instr_of(vecs[v].exp_addr[i]));
        check1($sformatf("v%0d pred%0d", v, i), delq[i].pred, vecs[v].exp_pred[i]);
      end
    end
    btb_en = 1'b0;

    // Redirect while waiting on a slow response.
    do_reset(3, 1'b1);
    wait_acc(1, "A accept");
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    #1;
    check1("A flush", flush, 1'b1);
    step();
    redirect_valid = 1'b0;
    #1;
    check1("A flush pulse", flush, 1'b0);
    wait_acc(2, "A reaccept");
    check("A redirect addr", accq[1], 32'h100);
    wait_del(1, "A delivered");
    check("A first pc", delq[0].pc, 32'h100);

    // Redirect while the request is not yet accepted.
    do_reset(1, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    #1;
    check1("B flush", flush, 1'b1);
    check("B addr0", imem_if.req_addr, 32'h0);
    step();
    redirect_valid = 1'b0;
    #1;
    check("B addr held", imem_if.req_addr, 32'h0);
    check1("B req_valid held", imem_if.req_valid, 1'b1);
    step();
    ready_en = 1'b1;
    #1;
    check("B addr at accept", imem_if.req_addr, 32'h0);
    wait_del(1, "B delivered");
    check("B first accept", accq[0], 32'h0);
    check("B second accept", accq[1], 32'h200);
    check("B first pc", delq[0].pc, 32'h200);

    // Four-cycle stall with the next response waiting.
    do_reset(1, 1'b1);
    wait_valid("C valid");
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check1($sformatf("C valid s%0d", i), if_valid, 1'b1);
      check($sformatf("C pc s%0d", i), if_pc, 32'h0);
      check($sformatf("C instr s%0d", i), if_instr, instr_of(32'h0));
      check1($sformatf("C rsp_ready s%0d", i), imem_if.rsp_ready, 1'b0);
      step();
    end
    stall = 1'b0;
    wait_del(3, "C delivered");
    check("C pc0", delq[0].pc, 32'h0);
    check("C pc1", delq[1].pc, 32'h4);
    check("C pc2", delq[2].pc, 32'h8);

    // Redirect together with stall, then reset in the middle of a read.
    do_reset(1, 1'b1);
    wait_valid("D valid");
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    #1;
    check1("D flush", flush, 1'b1);
    step();
    redirect_valid = 1'b0;
    #1;
    check1("D valid cleared", if_valid, 1'b0);
    stall = 1'b0;
    wait_del(1, "D delivered");
    check("D first pc", delq[0].pc, 32'h300);
    latency = 4;
    wait_acc(accq.size() + 1, "D slow accept");
    rst_n = 1'b0;
    #1;
    check1("D rst req_valid", imem_if.req_valid, 1'b0);
    check1("D rst rsp_ready", imem_if.rsp_ready, 1'b0);
    check1("D rst if_valid", if_valid, 1'b0);
    ready_en = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check("D restart addr", imem_if.req_addr, 32'h0);
    check1("D restart req_valid", imem_if.req_valid, 1'b1);
    begin
      int c = 0;
      while (!imem_if.rsp_valid && c < 20) begin
        step();
        c++;
      end
    end
    check1("D late rsp present", imem_if.rsp_valid, 1'b1);
    #1;
    check1("D late rsp_ready", imem_if.rsp_ready, 1'b0);
    check1("D late if_valid", if_valid, 1'b0);
    mem_reset = 1'b1;
    step();
    step();
    mem_reset = 1'b0;
    accq.delete();
    delq.delete();
    latency  = 1;
    ready_en = 1'b1;
    wait_del(1, "D after reset");
    check("D after reset addr", accq[0], 32'h0);
    check("D after reset pc", delq[0].pc, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
